// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer that drives one shared 4-bit full-adder slice, LSB nibble first.
// Optional macro SUB_EN adds a 'sub' port for two's-complement subtraction.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    // state | meaning
    // IDLE  | waiting for start; last result held
    // RUN   | one nibble per cycle through the slice
    // DONE  | result valid, done pulses; start accepted here too

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             sub_reg;
    logic [IW+1:0]    bit_base;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       b_eff;
    logic             accept;
    logic             last;

`ifdef SUB_EN
    logic sub_in;
    assign sub_in = sub;
`else
    logic sub_in;
    assign sub_in = 1'b0;
`endif

    assign bit_base = {idx, 2'b00};
    assign a_sh     = a_reg >> bit_base;
    assign b_sh     = b_reg >> bit_base;
    assign b_eff    = sub_reg ? ~b_sh[3:0] : b_sh[3:0];
    assign accept   = start && (state != RUN);
    assign last     = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_sh[3:0];
                add_b   = b_eff;
                add_cin = carry;
                if (last) next_state = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Slice outputs are only captured in RUN so X from an idle slice never lands in state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sub_reg <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            idx     <= '0;
            sub_reg <= sub_in;
            carry   <= sub_in ? 1'b1 : cin;
        end else if (state == RUN) begin
            result[bit_base +: 4] <= add_sum;
            carry                 <= add_cout;
            idx                   <= idx + 1'b1;
            if (last) begin
                cout <= add_cout;
                ovf  <= (a_reg[WIDTH-1] == b_eff[3]) && (add_sum[3] != a_reg[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        sub;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int passed;
    int total;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SUB_EN
        .sub      (sub),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Stand-in for the existing fulladder4bit slice.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        cin   = 1'b1;
        sub   = 1'b0;
        step;
        step;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result); else passed++;
        total++; if ({cout, ovf} !== 2'b00) $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); else passed++;
        total++; if ({add_a, add_b, add_cin} !== 9'd0) $display("FAIL reset_slice: got %h want 000", {add_a, add_b, add_cin}); else passed++;
        rst_n = 1'b1;
        cin   = 1'b0;
        step;
    endtask

    task automatic test_basic;
        logic [15:0] ea;
        logic [15:0] eb;
        ea = 16'h1234;
        eb = 16'h4321;
        drive(ea, eb, 1'b0, 1'b0);
        step;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total++; if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0)
                $display("FAIL basic_run_flags c%0d: got busy=%b done=%b ready=%b want 1 0 0", c, busy, done, ready);
            else passed++;
            total++; if (add_a !== ea[4*(c-1) +: 4] || add_b !== eb[4*(c-1) +: 4])
                $display("FAIL basic_slice c%0d: got a=%h b=%h want a=%h b=%h", c, add_a, add_b, ea[4*(c-1) +: 4], eb[4*(c-1) +: 4]);
            else passed++;
            step;
        end
        total++; if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1)
            $display("FAIL basic_done_flags: got done=%b busy=%b ready=%b want 1 0 1", done, busy, ready);
        else passed++;
        total++; if (result !== 16'h5555) $display("FAIL basic_result: got %h want 5555", result); else passed++;
        total++; if ({cout, ovf} !== 2'b00) $display("FAIL basic_cout_ovf: got %b want 00", {cout, ovf}); else passed++;
        step;
        total++; if (done !== 1'b0 || ready !== 1'b1 || add_a !== 4'd0)
            $display("FAIL basic_after: got done=%b ready=%b add_a=%h want 0 1 0", done, ready, add_a);
        else passed++;
    endtask

    task automatic test_carry_ripple;
        logic [4:0] exp_cin;
        exp_cin = 5'b11100;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total++; if (add_cin !== exp_cin[c])
                $display("FAIL carry_add_cin c%0d: got %b want %b", c, add_cin, exp_cin[c]);
            else passed++;
            step;
        end
        total++; if (done !== 1'b1) $display("FAIL carry_done: got %b want 1", done); else passed++;
        total++; if (result !== 16'h0000) $display("FAIL carry_result: got %h want 0000", result); else passed++;
        total++; if ({cout, ovf} !== 2'b10) $display("FAIL carry_cout_ovf: got %b want 10", {cout, ovf}); else passed++;
        step;
    endtask

    task automatic test_overflow;
        drive(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        step;
        start = 1'b0;
        cin   = 1'b0;
        for (int c = 1; c <= 4; c++) step;
        total++; if (done !== 1'b1) $display("FAIL ovf_done: got %b want 1", done); else passed++;
        total++; if (result !== 16'h8000) $display("FAIL ovf_result: got %h want 8000", result); else passed++;
        total++; if ({cout, ovf} !== 2'b01) $display("FAIL ovf_cout_ovf: got %b want 01", {cout, ovf}); else passed++;
        step;
    endtask

    task automatic test_back_to_back;
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        step;
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        cin  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            total++; if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL b2b_busy c%0d: got busy=%b done=%b want 1 0", c, busy, done);
            else passed++;
            step;
        end
        total++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else passed++;
        total++; if (result !== 16'h3333 || cout !== 1'b0)
            $display("FAIL b2b_first_result: got %h cout=%b want 3333 cout=0", result, cout);
        else passed++;
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        step;
        start = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            total++; if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL b2b_second_run c%0d: got busy=%b done=%b want 1 0", c, busy, done);
            else passed++;
            step;
        end
        total++; if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done); else passed++;
        total++; if (result !== 16'h0002) $display("FAIL b2b_second_result: got %h want 0002", result); else passed++;
        step;
        total++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %b want 0", done); else passed++;
    endtask

    task automatic test_reset_mid_run;
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        step;
        start = 1'b0;
        step;
        rst_n = 1'b0;
        #1;
        total++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_flags: got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done);
        else passed++;
        total++; if (result !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0)
            $display("FAIL midrst_result: got %h cout=%b ovf=%b want 0000 0 0", result, cout, ovf);
        else passed++;
        total++; if ({add_a, add_b, add_cin} !== 9'd0)
            $display("FAIL midrst_slice: got %h want 000", {add_a, add_b, add_cin});
        else passed++;
        step;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++; if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL midrst_no_done c%0d: got done=%b busy=%b want 0 0", c, done, busy);
            else passed++;
            step;
        end
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        step;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) step;
        total++; if (done !== 1'b1) $display("FAIL midrst_after_done: got %b want 1", done); else passed++;
        total++; if (result !== 16'h0100 || cout !== 1'b0)
            $display("FAIL midrst_after_result: got %h cout=%b want 0100 0", result, cout);
        else passed++;
        step;
    endtask

`ifdef SUB_EN
    task automatic test_sub;
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        step;
        start = 1'b0;
        total++; if (add_b !== 4'h8 || add_cin !== 1'b1)
            $display("FAIL sub_slice: got b=%h cin=%b want 8 1", add_b, add_cin);
        else passed++;
        for (int c = 1; c <= 4; c++) step;
        total++; if (done !== 1'b1 || result !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0)
            $display("FAIL sub_5m7: got done=%b %h cout=%b ovf=%b want 1 FFFE 0 0", done, result, cout, ovf);
        else passed++;
        drive(16'h0007, 16'h0005, 1'b0, 1'b1);
        step;
        start = 1'b0;
        sub   = 1'b0;
        for (int c = 1; c <= 4; c++) step;
        total++; if (done !== 1'b1 || result !== 16'h0002 || cout !== 1'b1)
            $display("FAIL sub_7m5: got done=%b %h cout=%b want 1 0002 1", done, result, cout);
        else passed++;
        step;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset;
        test_basic;
        test_carry_ripple;
        test_overflow;
        test_back_to_back;
        test_reset_mid_run;
`ifdef SUB_EN
        test_sub;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
